// File: rtl/btb_pkg.sv
// Shared types and counter helpers for the set-associative branch target buffer.
package btb_pkg;

    // Default counter width; each instance sizes its own counters from its CNT_W parameter.
    localparam int CNT_W_DEFAULT = 2;

    // Saturating direction counter at the default width.
    typedef logic [CNT_W_DEFAULT-1:0] cnt_t;

    // Largest counter value for a w-bit counter (strongly taken).
    function automatic logic [31:0] cnt_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

    // Value given to a freshly allocated entry: MSB set, all else clear (weakly taken).
    function automatic logic [31:0] cnt_init(input int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

    // Constants for the default width.
    localparam logic [31:0] CNT_MAX  = cnt_max(CNT_W_DEFAULT);
    localparam logic [31:0] CNT_INIT = cnt_init(CNT_W_DEFAULT);

    // Increment, holding at the w-bit maximum rather than wrapping to 0.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned w);
        return (val >= cnt_max(w)) ? val : val + 32'd1;
    endfunction

    // Decrement, holding at 0 rather than wrapping to the maximum.
    function automatic logic [31:0] sat_dec(input logic [31:0] val);
        return (val == 32'd0) ? val : val - 32'd1;
    endfunction

endpackage

// File: rtl/btb_way_select.sv
// Tag compare and way choice for one set: lowest matching way on a hit,
// lowest invalid way (else the round-robin way) as the allocation victim.
module btb_way_select
    import btb_pkg::*;
#(
    parameter int WAYS  = 2,
    parameter int TAG_W = 25,
    parameter int PTR_W = 1
) (
    input  logic [WAYS-1:0]            valid,
    input  logic [WAYS-1:0][TAG_W-1:0] tags,
    input  logic [TAG_W-1:0]           cmp_tag,
    input  logic [PTR_W-1:0]           rr_ptr,
    output logic                       hit,
    output logic [PTR_W-1:0]           hit_way,
    output logic [PTR_W-1:0]           victim_way
);

    logic [WAYS-1:0] match;

    for (genvar gi = 0; gi < WAYS; gi++) begin : g_match
        assign match[gi] = valid[gi] && (tags[gi] == cmp_tag);
    end

    assign hit = |match;

    // Priority-encode the matches; scanning downwards leaves the lowest way.
    always_comb begin
        hit_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit_way = PTR_W'(i);
            end
        end
    end

    // Prefer an empty way; only a full set falls back to the round-robin pointer.
    always_comb begin
        victim_way = rr_ptr;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                victim_way = PTR_W'(i);
            end
        end
    end

endmodule

// File: rtl/btb_assoc.sv
// Tagged set-associative branch target buffer: combinational fetch lookup,
// execute-stage update and synchronous flush on the rising clock edge.
module btb_assoc
    import btb_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int WAYS    = 2,
    parameter int XLEN    = 32,
    parameter int CNT_W   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic [XLEN-1:0] lookup_pc_i,
    output logic            hit_o,
    output logic            prediction_o,
    output logic [XLEN-1:0] target_o,
    input  logic            update_en_i,
    input  logic [XLEN-1:0] update_pc_i,
    input  logic [XLEN-1:0] update_target_i,
    input  logic            update_taken_i,
    input  logic            update_is_jump_i
);

    localparam int SETS    = ENTRIES / WAYS;
    localparam int INDEX_W = $clog2(SETS);
    localparam int TAG_W   = XLEN - 2 - INDEX_W;
    // A single-set or single-way build still gets a 1-bit index/pointer held at 0.
    localparam int IDX_W   = (INDEX_W > 0) ? INDEX_W : 1;
    localparam int PTR_W   = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
        logic [CNT_W-1:0] cnt;
        logic             is_jump;
    } btb_entry_t;

    // Flop-based storage: one entry per (set, way), one replacement pointer per set.
    btb_entry_t       entry_reg [SETS][WAYS];
    logic [PTR_W-1:0] rr_reg    [SETS];

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;

    if (INDEX_W > 0) begin : g_idx
        assign lk_idx = lookup_pc_i[INDEX_W+1:2];
        assign up_idx = update_pc_i[INDEX_W+1:2];
    end else begin : g_idx_none
        assign lk_idx = '0;
        assign up_idx = '0;
    end

    assign lk_tag = lookup_pc_i[XLEN-1:INDEX_W+2];
    assign up_tag = update_pc_i[XLEN-1:INDEX_W+2];

    // Per-way valid/tag vectors of the two addressed sets.
    logic [WAYS-1:0]            lk_valid, up_valid;
    logic [WAYS-1:0][TAG_W-1:0] lk_tags, up_tags;

    for (genvar gi = 0; gi < WAYS; gi++) begin : g_vec
        assign lk_valid[gi] = entry_reg[lk_idx][gi].valid;
        assign lk_tags[gi]  = entry_reg[lk_idx][gi].tag;
        assign up_valid[gi] = entry_reg[up_idx][gi].valid;
        assign up_tags[gi]  = entry_reg[up_idx][gi].tag;
    end

    logic             lk_hit, up_hit;
    logic [PTR_W-1:0] lk_way, lk_victim, up_hit_way, up_victim;

    btb_way_select #(
        .WAYS  (WAYS),
        .TAG_W (TAG_W),
        .PTR_W (PTR_W)
    ) u_lookup_sel (
        .valid      (lk_valid),
        .tags       (lk_tags),
        .cmp_tag    (lk_tag),
        .rr_ptr     (rr_reg[lk_idx]),
        .hit        (lk_hit),
        .hit_way    (lk_way),
        .victim_way (lk_victim)
    );

    btb_way_select #(
        .WAYS  (WAYS),
        .TAG_W (TAG_W),
        .PTR_W (PTR_W)
    ) u_update_sel (
        .valid      (up_valid),
        .tags       (up_tags),
        .cmp_tag    (up_tag),
        .rr_ptr     (rr_reg[up_idx]),
        .hit        (up_hit),
        .hit_way    (up_hit_way),
        .victim_way (up_victim)
    );

    // Lookup outputs come straight from current state; there is no update bypass.
    btb_entry_t lk_entry;
    assign lk_entry     = entry_reg[lk_idx][lk_way];
    assign hit_o        = lk_hit;
    assign prediction_o = lk_hit & (lk_entry.is_jump | lk_entry.cnt[CNT_W-1]);
    assign target_o     = lk_hit ? lk_entry.target : '0;

    btb_entry_t       up_old, up_new;
    logic [PTR_W-1:0] up_way, rr_next;
    logic             up_alloc, up_write, up_rotate;

    // Decide what the update writes: refresh a hit in place, or allocate on a
    // taken/jump miss; not-taken misses leave the table untouched.
    always_comb begin
        up_way    = up_hit ? up_hit_way : up_victim;
        up_old    = entry_reg[up_idx][up_way];
        up_alloc  = ~up_hit & (update_taken_i | update_is_jump_i);
        up_write  = update_en_i & (up_hit | up_alloc);
        // The pointer only advances when a full set forces an eviction.
        up_rotate = up_alloc & (&up_valid);
        rr_next   = (WAYS > 1) ? rr_reg[up_idx] + 1'b1 : '0;

        up_new         = '0;
        up_new.valid   = 1'b1;
        up_new.tag     = up_tag;
        up_new.target  = update_target_i;
        up_new.is_jump = update_is_jump_i;
        if (up_hit) begin
            up_new.cnt = update_taken_i ? CNT_W'(sat_inc(32'(up_old.cnt), CNT_W))
                                        : CNT_W'(sat_dec(32'(up_old.cnt)));
        end else begin
            up_new.cnt = CNT_W'(cnt_init(CNT_W));
        end
    end

    // Fields read only for their width or not at all on a given path.
    logic unused_bits;
    assign unused_bits = ^{lookup_pc_i[1:0], update_pc_i[1:0], lk_victim,
                           lk_entry.valid, lk_entry.tag, up_old.valid, up_old.tag,
                           up_old.target, up_old.is_jump};

    // Table state: async clear, then flush wins over a same-cycle update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                rr_reg[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    entry_reg[s][w] <= '0;
                end
            end
        end else if (flush_i) begin
            for (int s = 0; s < SETS; s++) begin
                rr_reg[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    entry_reg[s][w].valid <= 1'b0;
                end
            end
        end else if (up_write) begin
            entry_reg[up_idx][up_way] <= up_new;
            if (up_rotate) begin
                rr_reg[up_idx] <= rr_next;
            end
        end
    end

endmodule
